display_scan_ctrl: RTL and testbench

Time-division multiplexing controller for the 4-digit seven-segment display. It takes the four segment-pattern registers from the display register block and scans them onto shared cathode lines, strobing one anode at a time. A dead-time gap between digits suppresses ghosting. It emits a once-per-frame pulse for firmware or test synchronisation.

---
 rtl/display_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a 4-digit seven-segment
//            display. Strobes one anode at a time with a dead-time gap
//            between digits and emits a one-clock pulse at each frame wrap.
//            Optional macro DISPLAY_SCAN_BRIGHTNESS_EN adds a 4-bit PWM
//            brightness control on the lit anode.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter logic [15:0] DIGIT_CYCLES       = 16'd50000,
    parameter logic [7:0]  DEAD_CYCLES        = 8'd16,
    parameter bit          ANODE_ACTIVE_LOW   = 1'b1,
    parameter bit          CATHODE_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] blank_mask,
    input  logic [7:0] segment0,
    input  logic [7:0] segment1,
    input  logic [7:0] segment2,
    input  logic [7:0] segment3,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    input  logic [3:0] brightness,
`endif
    output logic [3:0] anode,
    output logic [7:0] cathode,
    output logic [1:0] digit_sel,
    output logic       frame_pulse
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;

    localparam logic [15:0] c_show_last = DIGIT_CYCLES - 16'd1;
    localparam logic [15:0] c_dead_last = {8'd0, DEAD_CYCLES} - 16'd1;
    localparam logic [3:0]  c_anode_off   = ANODE_ACTIVE_LOW   ? 4'hF  : 4'h0;
    localparam logic [7:0]  c_cathode_off = CATHODE_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_digit_sel;
    logic [3:0]  r_anode;
    logic [7:0]  r_cathode;
    logic        r_frame_pulse;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  w_digit_nxt;
    logic        w_frame_nxt;
    logic [7:0]  w_seg_sel;
    logic        w_pwm_on;
    logic [3:0]  w_anode_act;
    logic [7:0]  w_cathode_act;
    logic [3:0]  w_anode_nxt;
    logic [7:0]  w_cathode_nxt;

    // State, counter, digit index and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 16'd0;
            r_digit_sel   <= 2'd0;
            r_frame_pulse <= 1'b0;
            r_anode       <= c_anode_off;
            r_cathode     <= c_cathode_off;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_digit_sel   <= w_digit_nxt;
            r_frame_pulse <= w_frame_nxt;
            r_anode       <= w_anode_nxt;
            r_cathode     <= w_cathode_nxt;
        end
    end

    // Next-state logic: digit advance and frame wrap happen on SHOW entry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_digit_nxt = r_digit_sel;
        w_frame_nxt = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 16'd0;
            w_digit_nxt = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Entry from IDLE starts at digit 0 without a frame pulse
                    w_state_nxt = S_SHOW;
                    w_cnt_nxt   = 16'd0;
                    w_digit_nxt = 2'd0;
                end
                S_SHOW: begin
                    if (r_cnt == c_show_last) begin
                        w_cnt_nxt = 16'd0;
                        if (DEAD_CYCLES == 8'd0) begin
                            w_state_nxt = S_SHOW;
                            w_digit_nxt = r_digit_sel + 2'd1;
                            w_frame_nxt = (r_digit_sel == 2'd3);
                        end else begin
                            w_state_nxt = S_DEAD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_DEAD: begin
                    if (r_cnt == c_dead_last) begin
                        w_cnt_nxt   = 16'd0;
                        w_state_nxt = S_SHOW;
                        w_digit_nxt = r_digit_sel + 2'd1;
                        w_frame_nxt = (r_digit_sel == 2'd3);
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_digit_nxt = 2'd0;
                end
            endcase
        end
    end

    // Pattern of the digit being entered
    always_comb begin
        w_seg_sel = segment0;
        case (w_digit_nxt)
            2'd0:    w_seg_sel = segment0;
            2'd1:    w_seg_sel = segment1;
            2'd2:    w_seg_sel = segment2;
            default: w_seg_sel = segment3;
        endcase
    end

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [3:0] r_pwm;
    logic [3:0] w_pwm_nxt;

    // PWM phase restarts on every SHOW entry, including back-to-back digits
    always_comb begin
        w_pwm_nxt = 4'd0;
        if (w_state_nxt == S_SHOW && r_state == S_SHOW && w_cnt_nxt != 16'd0)
            w_pwm_nxt = r_pwm + 4'd1;
        w_pwm_on = (brightness == 4'hF) || (w_pwm_nxt < brightness);
    end

    // PWM phase register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pwm <= 4'd0;
        else       r_pwm <= w_pwm_nxt;
    end
`else
    // Without brightness control the anode is lit for the whole slot
    always_comb begin
        w_pwm_on = 1'b1;
    end
`endif

    // Output decode for the state being entered, then polarity
    always_comb begin
        w_anode_act   = 4'h0;
        w_cathode_act = 8'h00;
        if (w_state_nxt == S_SHOW) begin
            w_cathode_act = w_seg_sel;
            if (!blank_mask[w_digit_nxt] && w_pwm_on)
                w_anode_act = 4'b0001 << w_digit_nxt;
        end
        w_anode_nxt   = ANODE_ACTIVE_LOW   ? ~w_anode_act   : w_anode_act;
        w_cathode_nxt = CATHODE_ACTIVE_LOW ? ~w_cathode_act : w_cathode_act;
    end

    assign anode       = r_anode;
    assign cathode     = r_cathode;
    assign digit_sel   = r_digit_sel;
    assign frame_pulse = r_frame_pulse;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Directed self-checking bench for display_scan_ctrl. Runs a
//            4/1 scan instance and a 4/0 (no dead time) instance side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] blank_mask;
    logic [7:0] seg_tab [4];
    logic [3:0] brightness;

    logic [3:0] anode_a,  anode_z;
    logic [7:0] cathode_a, cathode_z;
    logic [1:0] dsel_a,   dsel_z;
    logic       fp_a,     fp_z;

    int n_err;
    int n_chk;

    display_scan_ctrl #(.DIGIT_CYCLES(16'd4), .DEAD_CYCLES(8'd1)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .blank_mask(blank_mask),
        .segment0(seg_tab[0]), .segment1(seg_tab[1]),
        .segment2(seg_tab[2]), .segment3(seg_tab[3]),
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .anode(anode_a), .cathode(cathode_a), .digit_sel(dsel_a), .frame_pulse(fp_a)
    );

    display_scan_ctrl #(.DIGIT_CYCLES(16'd4), .DEAD_CYCLES(8'd0)) u_dut_z (
        .clk(clk), .reset(reset), .enable(enable), .blank_mask(blank_mask),
        .segment0(seg_tab[0]), .segment1(seg_tab[1]),
        .segment2(seg_tab[2]), .segment3(seg_tab[3]),
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .anode(anode_z), .cathode(cathode_z), .digit_sel(dsel_z), .frame_pulse(fp_z)
    );

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [3:0] anode_b;
    logic [7:0] cathode_b;
    logic [1:0] dsel_b;
    logic       fp_b;

    display_scan_ctrl #(.DIGIT_CYCLES(16'd16), .DEAD_CYCLES(8'd1)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .blank_mask(blank_mask),
        .segment0(seg_tab[0]), .segment1(seg_tab[1]),
        .segment2(seg_tab[2]), .segment3(seg_tab[3]),
        .brightness(brightness),
        .anode(anode_b), .cathode(cathode_b), .digit_sel(dsel_b), .frame_pulse(fp_b)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold the scan in IDLE for one clock; the next tick is scan cycle 0
    task automatic restart;
        enable = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    // Expected outputs at scan cycle k (k = 0 is the first SHOW cycle)
    function automatic void exp_scan(input int k, input int show_n, input int dead_n,
                                     input logic [3:0] mask,
                                     output logic [3:0] an, output logic [7:0] ca,
                                     output logic fp, output logic [1:0] ds);
        int per, pos, dg, slot;
        logic [3:0] oh;
        per  = show_n + dead_n;
        pos  = k % (4 * per);
        dg   = pos / per;
        slot = pos % per;
        ds   = dg[1:0];
        fp   = (k > 0) && (pos == 0);
        oh   = 4'b0001 << dg;
        if (slot < show_n) begin
            ca = ~seg_tab[dg];
            an = mask[dg] ? 4'hF : ~oh;
        end else begin
            an = 4'hF;
            ca = 8'hFF;
        end
    endfunction

    task automatic test_reset;
        n_chk++; if (anode_a !== 4'hF) begin n_err++; $display("FAIL reset_anode got %h expected %h", anode_a, 4'hF); end
        n_chk++; if (cathode_a !== 8'hFF) begin n_err++; $display("FAIL reset_cathode got %h expected %h", cathode_a, 8'hFF); end
        n_chk++; if (fp_a !== 1'b0) begin n_err++; $display("FAIL reset_frame got %b expected 0", fp_a); end
        n_chk++; if (dsel_a !== 2'd0) begin n_err++; $display("FAIL reset_digit got %0d expected 0", dsel_a); end
    endtask

    task automatic test_basic_scan;
        logic [3:0] an; logic [7:0] ca; logic fp; logic [1:0] ds;
        restart();
        for (int k = 0; k < 44; k++) begin
            tick();
            exp_scan(k, 4, 1, 4'b0000, an, ca, fp, ds);
            n_chk++; if (anode_a !== an) begin n_err++; $display("FAIL scan_anode k=%0d got %b expected %b", k, anode_a, an); end
            n_chk++; if (cathode_a !== ca) begin n_err++; $display("FAIL scan_cathode k=%0d got %h expected %h", k, cathode_a, ca); end
            n_chk++; if (fp_a !== fp) begin n_err++; $display("FAIL scan_frame k=%0d got %b expected %b", k, fp_a, fp); end
            n_chk++; if (dsel_a !== ds) begin n_err++; $display("FAIL scan_digit k=%0d got %0d expected %0d", k, dsel_a, ds); end
        end
    endtask

    task automatic test_zero_dead;
        logic [3:0] an; logic [7:0] ca; logic fp; logic [1:0] ds;
        restart();
        for (int k = 0; k < 36; k++) begin
            tick();
            exp_scan(k, 4, 0, 4'b0000, an, ca, fp, ds);
            n_chk++; if (anode_z !== an) begin n_err++; $display("FAIL zdead_anode k=%0d got %b expected %b", k, anode_z, an); end
            n_chk++; if (cathode_z !== ca) begin n_err++; $display("FAIL zdead_cathode k=%0d got %h expected %h", k, cathode_z, ca); end
            n_chk++; if (fp_z !== fp) begin n_err++; $display("FAIL zdead_frame k=%0d got %b expected %b", k, fp_z, fp); end
        end
    endtask

    task automatic test_blanking;
        logic [3:0] an; logic [7:0] ca; logic fp; logic [1:0] ds;
        blank_mask = 4'b0100;
        restart();
        for (int k = 0; k < 41; k++) begin
            tick();
            exp_scan(k, 4, 1, 4'b0100, an, ca, fp, ds);
            n_chk++; if (anode_a !== an) begin n_err++; $display("FAIL blank_anode k=%0d got %b expected %b", k, anode_a, an); end
            n_chk++; if (fp_a !== fp) begin n_err++; $display("FAIL blank_frame k=%0d got %b expected %b", k, fp_a, fp); end
        end
        blank_mask = 4'b0000;
    endtask

    task automatic test_enable_drop;
        restart();
        for (int k = 0; k < 12; k++) tick();
        // scan cycle 11 is the second SHOW clock of digit 2
        n_chk++; if (anode_a !== 4'b1011) begin n_err++; $display("FAIL drop_pre_anode got %b expected 1011", anode_a); end
        enable = 1'b0;
        tick();
        n_chk++; if (anode_a !== 4'hF) begin n_err++; $display("FAIL drop_anode got %h expected F", anode_a); end
        n_chk++; if (cathode_a !== 8'hFF) begin n_err++; $display("FAIL drop_cathode got %h expected FF", cathode_a); end
        n_chk++; if (dsel_a !== 2'd0) begin n_err++; $display("FAIL drop_digit got %0d expected 0", dsel_a); end
        n_chk++; if (fp_a !== 1'b0) begin n_err++; $display("FAIL drop_frame got %b expected 0", fp_a); end
        enable = 1'b1;
        tick();
        n_chk++; if (anode_a !== 4'b1110) begin n_err++; $display("FAIL reen_anode got %b expected 1110", anode_a); end
        n_chk++; if (cathode_a !== 8'hC0) begin n_err++; $display("FAIL reen_cathode got %h expected C0", cathode_a); end
        n_chk++; if (fp_a !== 1'b0) begin n_err++; $display("FAIL reen_frame got %b expected 0", fp_a); end
        n_chk++; if (dsel_a !== 2'd0) begin n_err++; $display("FAIL reen_digit got %0d expected 0", dsel_a); end
    endtask

    task automatic test_segment_update;
        restart();
        tick();
        n_chk++; if (cathode_a !== 8'hC0) begin n_err++; $display("FAIL segupd_before got %h expected C0", cathode_a); end
        seg_tab[0] = 8'h77;
        tick();
        n_chk++; if (cathode_a !== 8'h88) begin n_err++; $display("FAIL segupd_after got %h expected 88", cathode_a); end
        seg_tab[0] = 8'h3F;
    endtask

    task automatic test_async_reset;
        restart();
        tick();
        tick();
        n_chk++; if (anode_a !== 4'b1110) begin n_err++; $display("FAIL areset_pre got %b expected 1110", anode_a); end
        #2 reset = 1'b1;
        #1;
        n_chk++; if (anode_a !== 4'hF) begin n_err++; $display("FAIL areset_anode got %h expected F", anode_a); end
        n_chk++; if (cathode_a !== 8'hFF) begin n_err++; $display("FAIL areset_cathode got %h expected FF", cathode_a); end
        n_chk++; if (fp_a !== 1'b0) begin n_err++; $display("FAIL areset_frame got %b expected 0", fp_a); end
        #1 reset = 1'b0;
        tick();
    endtask

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    task automatic test_brightness;
        logic [3:0] ea;
        brightness = 4'd4;
        restart();
        for (int k = 0; k < 16; k++) begin
            tick();
            ea = (k < 4) ? 4'b1110 : 4'b1111;
            n_chk++; if (anode_b !== ea) begin n_err++; $display("FAIL bright4 k=%0d got %b expected %b", k, anode_b, ea); end
        end
        brightness = 4'hF;
        restart();
        for (int k = 0; k < 16; k++) begin
            tick();
            n_chk++; if (anode_b !== 4'b1110) begin n_err++; $display("FAIL brightF k=%0d got %b expected 1110", k, anode_b); end
        end
    endtask
`endif

    initial begin
        n_err      = 0;
        n_chk      = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        blank_mask = 4'b0000;
        brightness = 4'hF;
        seg_tab[0] = 8'h3F;
        seg_tab[1] = 8'h06;
        seg_tab[2] = 8'h5B;
        seg_tab[3] = 8'h4F;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_basic_scan();
        test_blanking();
        test_enable_drop();
        test_zero_dead();
        test_segment_update();
        test_async_reset();
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
